// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Free-running 4-digit scan scheduler for a seven-segment display. Each digit
//   slot lasts TICK_DIV cycles; the first BLANK_CYCLES of every slot are blanked
//   to hide anode switching. Digit values and the enable mask are
//   double-buffered: a load only lands in a one-entry pending buffer, which is
//   copied to the active set at the frame boundary (digit 3 -> digit 0).
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   load       : one-cycle strobe, captures digits_in/mask_in into pending
//   digits_in  : four 4-bit digit values, digit k at [4k+3:4k]
//   mask_in    : per-digit enable, bit k = 1 lights digit k
//   en_out     : current digit index to the anode decoder
//   digit_out  : active value of the current digit
//   blank      : 1 forces all segments off
//   frame_done : one-cycle pulse after the last cycle of digit 3
`timescale 1ns/1ps

module display_scan_controller #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned CNT_W        = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  mask_in,
  output logic [1:0]  en_out,
  output logic [3:0]  digit_out,
  output logic        blank,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [15:0]      act_digits_q;
  logic [3:0]       act_mask_q;
  logic [15:0]      pend_digits_q;
  logic [3:0]       pend_mask_q;
  logic             pend_valid_q;
  logic             frame_done_q;

  logic slot_end;
  logic frame_wrap;
  logic dead_time;

  assign slot_end   = (cnt_q == CntLast);
  assign frame_wrap = slot_end && (idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      act_digits_q  <= 16'h0000;
      act_mask_q    <= 4'b0000;
      pend_digits_q <= 16'h0000;
      pend_mask_q   <= 4'b0000;
      pend_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      frame_done_q <= frame_wrap;

      // Commit uses the pending contents as they were before this edge, so a
      // load landing on the boundary edge waits for the next frame.
      if (frame_wrap && pend_valid_q) begin
        act_digits_q <= pend_digits_q;
        act_mask_q   <= pend_mask_q;
      end

      if (load) begin
        pend_digits_q <= digits_in;
        pend_mask_q   <= mask_in;
        pend_valid_q  <= 1'b1;
      end else if (frame_wrap) begin
        pend_valid_q  <= 1'b0;
      end
    end
  end

  // A zero-length dead time would make the compare constant-false.
  if (BLANK_CYCLES == 0) begin : g_no_dead
    assign dead_time = 1'b0;
  end else begin : g_dead
    localparam logic [CNT_W-1:0] BlankEnd = CNT_W'(BLANK_CYCLES);
    assign dead_time = (cnt_q < BlankEnd);
  end

  assign en_out     = idx_q;
  assign digit_out  = act_digits_q[{idx_q, 2'b00} +: 4];
  assign blank      = dead_time || !act_mask_q[idx_q];
  assign frame_done = frame_done_q;

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexing scheduler for the 4-digit seven-segment display.
- Steps a 2-bit digit select through 0..3 at a programmable rate and drives the anode decoder's `en` input.
- Presents the selected digit's 4-bit value to the segment encoder.
- Applies dead-time blanking at each digit switch to suppress ghosting.
- Double-buffers digit values and the enable mask so they change only at frame boundaries. This prevents tearing when game logic updates score/timer mid-scan.

Parameters:
- TICK_DIV, 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz). Legal range ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot during which the display is blanked. Legal range 0 ≤ BLANK_CYCLES < TICK_DIV.
- CNT_W, 17: prescaler counter width. Must satisfy 2^CNT_W ≥ TICK_DIV.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- load, input, 1: single-cycle strobe; capture digits_in and mask_in into the pending buffer.
- digits_in, input, 16: digit values; digit k occupies bits [4k+3:4k].
- mask_in, input, 4: per-digit enable; bit k = 1 means digit k is lit.
- en_out, output, 2: current digit index, connected to the anode decoder `en`.
- digit_out, output, 4: active value of the current digit.
- blank, output, 1: 1 = segment encoder must drive all segments off.
- frame_done, output, 1: one-cycle pulse when the scan wraps from digit 3 to digit 0.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - Prescaler cnt = 0, idx = 0.
  - Active digits = 16'h0000, active mask = 4'b0000.
  - Pending digits = 0, pending mask = 0, pend_valid = 0.
  - frame_done = 0.
  - Outputs: en_out = 0, digit_out = 0, blank = 1.
  - Reset mid-frame abandons the scan immediately; on release, scanning restarts at idx 0, cnt 0.
- Prescaler:
  - cnt increments every cycle.
  - At cnt == TICK_DIV-1: cnt ← 0 and idx ← idx+1 (mod 4; 3 wraps to 0).
- Slot length:
  - Each digit is held exactly TICK_DIV cycles.
  - A frame is exactly 4·TICK_DIV cycles.
- Outputs:
  - en_out = idx (registered).
  - digit_out = active_digits[4·idx+3 : 4·idx], combinational from registered state, updating in the same cycle as idx.
  - blank = (cnt < BLANK_CYCLES) OR (active_mask[idx] == 0).
  - With BLANK_CYCLES = 0, only the mask blanks.
- Frame boundary: the clock edge where cnt == TICK_DIV-1 and idx == 3.
  - frame_done is registered high for the following cycle only.
  - If pend_valid = 1: active_digits ← pending digits, active_mask ← pending mask, pend_valid ← 0.
  - The new values take effect on the first cycle of digit 0.
- Load:
  - On load = 1: pending ← digits_in / mask_in, pend_valid ← 1.
  - Multiple loads within a frame: last one wins.
- Load coinciding with the frame boundary:
  - The boundary commits the previously pending contents.
  - The new load is written to pending, and pend_valid stays 1.
  - The new value commits at the next boundary.
  - If pend_valid was 0, the boundary commits nothing and the new load is pending.
- Latency: load-to-display is between 1 and 4·TICK_DIV cycles, always starting at digit 0.
- No other state machine: a free-running scan with a 1-entry commit buffer.

Test Plan:
- Reset blanking: TICK_DIV = 8, BLANK_CYCLES = 2. Hold rst_n = 0 for 5 cycles, then release.
  - During reset: blank = 1, en_out = 0, frame_done = 0.
  - After release: en_out sequence 0,1,2,3,0 with each value held exactly 8 cycles.
  - blank stays 1 throughout, because mask = 0.
- Frame commit: load digits_in = 16'h4321, mask_in = 4'b1111 at cycle 5 of digit 1.
  - Output unchanged until the boundary.
  - frame_done pulses for 1 cycle after digit 3's last cycle.
  - Then digit_out = 1,2,3,4 for en_out = 0,1,2,3.
  - blank = 1 for cnt 0–1 and 0 for cnt 2–7 of each slot.
- Masking: commit mask_in = 4'b0101.
  - blank = 1 for the whole slot when en_out = 1 and when en_out = 3.
  - Digits 0 and 2 follow normal dead-time blanking.
- Last-load-wins and boundary collision: load 16'hAAAA mid-frame, then load 16'hBBBB on the boundary edge.
  - Next frame shows A on all digits.
  - The frame after shows B on all digits.
- Asynchronous reset mid-operation: assert rst_n low at idx = 2, cnt = 5 between clock edges.
  - Outputs reset without waiting for a clock edge: en_out = 0, blank = 1.
  - Previously committed digits are cleared to 0.
- Zero blanking: BLANK_CYCLES = 0, mask 4'b1111.
  - blank = 0 continuously after commit.
  - Period check: frame_done pulses exactly every 32 cycles.
